// File: rtl/chroma_upsampler.sv
// chroma_upsampler: takes one BxB chroma block per handshake and emits 1, 2 or 4 pixel-replicated BxB sub-blocks.
// Ports: clk/rst_n (async active-low); mode_in/ch_in/block_in/valid_in/in_ready input handshake;
//        block_out/ch_out/idx_out/last_out/valid_out/out_ready output handshake.
module chroma_upsampler #(
  parameter int PIX_W = 8,
  parameter int B = 8,
  parameter int CH = 2,
  localparam int CW = $clog2(CH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [1:0]                            mode_in,
  input  logic [CW-1:0]                         ch_in,
  input  logic                                  valid_in,
  output logic                                  in_ready,
  input  logic signed [B-1:0][B-1:0][PIX_W-1:0] block_in,
  output logic                                  valid_out,
  input  logic                                  out_ready,
  output logic signed [B-1:0][B-1:0][PIX_W-1:0] block_out,
  output logic [CW-1:0]                         ch_out,
  output logic [1:0]                            idx_out,
  output logic                                  last_out
);
  localparam int H = B / 2;
  localparam int RW = $clog2(B);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t st, st_nx;
  logic [B-1:0][B-1:0][PIX_W-1:0] blk;
  logic [1:0] mode, k, k_nx, kmax;
  logic [CW-1:0] ch;
  logic accept, take, hx, vx, kv;
  logic [RW-1:0] ri [B];
  logic [RW-1:0] ci [B];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      k <= '0;
      blk <= '0;
      mode <= '0;
      ch <= '0;
    end else begin
      st <= st_nx;
      k <= k_nx;
      if (accept) begin
        blk <= block_in;
        mode <= mode_in;
        ch <= ch_in;
      end
    end
  always_comb begin
    accept = valid_in & in_ready;
    take = valid_out & out_ready;
    st_nx = accept ? EMIT : (take & last_out) ? IDLE : st;
    k_nx = (accept | (take & last_out)) ? 2'd0 : take ? k + 2'd1 : k;
  end
  always_comb begin
    kmax = (mode == 2'b00) ? 2'd0 : (mode == 2'b10) ? 2'd3 : 2'd1;
    valid_out = (st == EMIT);
    last_out = valid_out & (k == kmax);
    in_ready = !valid_out | (last_out & out_ready);
    idx_out = k;
    ch_out = ch;
  end
  // Horizontal doubling for H2V1/H2V2, vertical for H2V2/H1V2; in H2V2 k[1] picks the lower half.
  assign hx = mode[0] ^ mode[1];
  assign vx = mode[1];
  assign kv = (mode == 2'b10) ? k[1] : k[0];
  for (genvar i = 0; i < B; i++) begin : g_idx
    assign ri[i] = vx ? RW'(kv ? H + i / 2 : i / 2) : RW'(i);
    assign ci[i] = hx ? RW'(k[0] ? H + i / 2 : i / 2) : RW'(i);
  end
  for (genvar r = 0; r < B; r++) begin : g_r
    for (genvar c = 0; c < B; c++) begin : g_c
      assign block_out[r][c] = blk[ri[r]][ci[c]];
    end
  end
endmodule

// File: tb/tb_chroma_upsampler.sv
// tb_chroma_upsampler: randomized and directed checks of chroma_upsampler against a beat-queue reference model.
module tb_chroma_upsampler;
  localparam int PIX_W = 8, B = 8, CH = 2, CW = $clog2(CH + 1), H = B / 2, W = B * B * PIX_W;
  typedef struct {
    logic [W-1:0] d;
    logic [1:0] idx;
    logic last;
    logic [CW-1:0] ch;
  } beat_t;
  logic clk = 0, rst_n = 0, valid_in = 0, out_ready = 1, valid_out, in_ready, last_out;
  logic [1:0] mode_in = 0, idx_out;
  logic [CW-1:0] ch_in = 0, ch_out;
  logic signed [B-1:0][B-1:0][PIX_W-1:0] bin = '0, bout;
  beat_t q[$];
  int n_chk = 0, n_fail = 0;
  bit done = 0;
  chroma_upsampler #(.PIX_W(PIX_W), .B(B), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .ch_in(ch_in), .valid_in(valid_in),
    .in_ready(in_ready), .block_in(bin), .valid_out(valid_out), .out_ready(out_ready),
    .block_out(bout), .ch_out(ch_out), .idx_out(idx_out), .last_out(last_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] up(input logic [1:0] m, input int k, input logic [W-1:0] src);
    logic [W-1:0] res;
    int sr, sc;
    for (int r = 0; r < B; r++)
      for (int c = 0; c < B; c++) begin
        case (m)
          2'b00: begin sr = r; sc = c; end
          2'b01: begin sr = r; sc = k * H + c / 2; end
          2'b11: begin sr = k * H + r / 2; sc = c; end
          default: begin sr = (k >> 1) * H + r / 2; sc = (k & 1) * H + c / 2; end
        endcase
        res[(r * B + c) * PIX_W +: PIX_W] = src[(sr * B + sc) * PIX_W +: PIX_W];
      end
    return res;
  endfunction
  function automatic logic [W-1:0] ramp();
    logic [W-1:0] res;
    for (int r = 0; r < B; r++)
      for (int c = 0; c < B; c++) res[(r * B + c) * PIX_W +: PIX_W] = PIX_W'(r * 8 + c + 1);
    return res;
  endfunction
  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] res;
    for (int i = 0; i < B * B; i++) res[i * PIX_W +: PIX_W] = PIX_W'(v);
    return res;
  endfunction
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] res;
    for (int i = 0; i < W; i++) res[i] = 1'($urandom_range(0, 1));
    return res;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      check("rst_valid", valid_out, 0);
      check("rst_block", bout, 0);
      check("rst_idx", idx_out, 0);
      check("rst_last", last_out, 0);
      check("rst_ch", ch_out, 0);
      check("rst_in_ready", in_ready, 1);
    end else begin
      check("valid", valid_out, q.size() != 0);
      check("in_ready", in_ready, q.size() == 0 || (q.size() == 1 && out_ready));
      if (valid_out && q.size() != 0) begin
        check("block", bout, q[0].d);
        check("idx", idx_out, q[0].idx);
        check("last", last_out, q[0].last);
        check("ch", ch_out, q[0].ch);
        if (out_ready) void'(q.pop_front());
      end
      if (valid_in && in_ready) begin
        int n;
        n = (mode_in == 2'b00) ? 1 : (mode_in == 2'b10) ? 4 : 2;
        for (int k = 0; k < n; k++) q.push_back('{up(mode_in, k, bin), 2'(k), k == n - 1, ch_in});
      end
    end
  end
  task automatic send(input logic [1:0] m, input logic [CW-1:0] c, input logic [W-1:0] d);
    int n;
    @(posedge clk);
    #1;
    mode_in = m;
    ch_in = c;
    bin = d;
    valid_in = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    check("send_ready", in_ready, 1);
    @(posedge clk);
    #1 valid_in = 0;
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    mode_in = 2'b10;
    ch_in = 1;
    bin = ramp();
    valid_in = 1;
    repeat (5) @(posedge clk);
    #1;
    valid_in = 0;
    rst_n = 1;
    send(2'b10, 1, ramp());
    @(negedge clk);
    check("h2v2_k0_00", bout[0][0], 1);
    check("h2v2_k0_11", bout[1][1], 1);
    check("h2v2_k0_77", bout[7][7], 28);
    fork
      send(2'b00, 2, fill(-5));
      begin
        repeat (3) @(negedge clk);
        check("h2v2_k3_idx", idx_out, 3);
        check("h2v2_k3_00", bout[0][0], 37);
        check("h2v2_k3_77", bout[7][7], 64);
        check("b2b_in_ready", in_ready, 1);
      end
    join
    @(negedge clk);
    check("b2b_valid", valid_out, 1);
    check("b2b_ch", ch_out, 2);
    check("b2b_idx", idx_out, 0);
    check("b2b_last", last_out, 1);
    check("b2b_block", bout, fill(-5));
    send(2'b01, 1, ramp());
    @(posedge clk);
    #1 out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      check("stall_idx", idx_out, 1);
      check("stall_50", bout[5][0], 45);
      check("stall_51", bout[5][1], 45);
      check("stall_57", bout[5][7], 48);
    end
    @(posedge clk);
    #1 out_ready = 1;
    send(2'b11, 1, ramp());
    repeat (2) @(negedge clk);
    check("h1v2_idx", idx_out, 1);
    check("h1v2_03", bout[0][3], 36);
    check("h1v2_13", bout[1][3], 36);
    check("h1v2_70", bout[7][0], 57);
    send(2'b10, 2, rnd());
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("async_valid", valid_out, 0);
    check("async_idx", idx_out, 0);
    @(posedge clk);
    #2 rst_n = 1;
    send(2'b00, 1, rnd());
    @(negedge clk);
    check("post_rst_valid", valid_out, 1);
    check("post_rst_idx", idx_out, 0);
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(2'($urandom_range(0, 3)), CW'($urandom_range(1, CH)), rnd());
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chroma_upsampler.md
# chroma_upsampler

Parametrised chroma upsampler that sits between the dequant/IDCT path and colour conversion. It replaces the fixed single-shot 4x4 to 8x8 supersampler. It accepts one decoded BxB chroma block per handshake and emits HF*VF BxB output blocks, each a pixel-replicated quadrant or half of the input, according to a per-block sampling mode. Full valid/ready flow control runs on both sides with an internal one-block buffer.

## Interface
- PIX_W, 8: signed sample width.
- B, 8: block dimension; must be even, ≥2.
- CH, 2: highest channel tag (Cb=1, Cr=2); tag width CW = $clog2(CH+1).
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- mode_in  in  2  sampling mode: 00 H1V1, 01 H2V1, 10 H2V2, 11 H1V2.
- ch_in  in  CW  channel tag of block_in.
- valid_in  in  1  block_in/mode_in/ch_in valid.
- in_ready  out  1  block accepted on valid_in & in_ready.
- block_in  in  [B-1:0][B-1:0] x PIX_W signed  input block, [row][col], row 0 top, col 0 left.
- valid_out  out  1  block_out valid.
- out_ready  in  1  downstream accepts on valid_out & out_ready.
- block_out  out  [B-1:0][B-1:0] x PIX_W signed  upsampled block.
- ch_out  out  CW  tag of the captured block.
- idx_out  out  2  output sub-block index k.
- last_out  out  1  high on the final sub-block of the current input block.

## Operation
- States: IDLE and EMIT.
- IDLE: in_ready=1, valid_out=0. On accept, capture block_in, mode_in and ch_in into the buffer. Set k=0 and nblk = 1 (H1V1), 2 (H2V1, H1V2) or 4 (H2V2). Go to EMIT.
- EMIT: valid_out=1, idx_out=k, last_out=(k==nblk-1).
- EMIT, beat accepted and not last: k increments.
- EMIT, beat accepted and last: go to IDLE, unless a new block is accepted in the same cycle. In that case, recapture, set k=0, stay in EMIT.
- in_ready = IDLE | (EMIT & last_out & out_ready). This is the only combinational input-to-output path.
- Mapping uses h=B/2, r,c in 0..B-1:
  - H1V1: out[r][c] = in[r][c].
  - H2V1: k=0 left, k=1 right; out[r][c] = in[r][k*h + c/2].
  - H1V2: k=0 top, k=1 bottom; out[r][c] = in[k*h + r/2][c].
  - H2V2: k=0 TL, 1 TR, 2 BL, 3 BR; out[r][c] = in[(k>>1)*h + r/2][(k&1)*h + c/2].
- Division is integer (floor). Replication only, no arithmetic, no width change; samples pass bit-exact.
- block_out, ch_out, idx_out and last_out are functions of registered state only.
- Inputs are ignored outside an accepting cycle. Changes to mode_in or ch_in during EMIT do not affect the current block.

## Timing
- Reset (rst_n low, immediate, no clock needed):
  - state=IDLE, k=0, buffer=0.
  - valid_out=0, block_out=0, ch_out=0, idx_out=0, last_out=0.
  - in_ready=1, but no capture occurs while rst_n is low.
- Latency: a block accepted at edge N drives valid_out=1, k=0 in the cycle after edge N.
- Throughput: nblk output beats per input block. Back-to-back blocks produce no bubble when the next valid_in coincides with the last accepted beat.
- Stall: while valid_out & !out_ready, all outputs and k hold stable. valid_out never drops without a handshake, except on reset.
- Reset mid-EMIT discards the buffered block and any remaining beats. The first block after reset starts at k=0.
- Simultaneous last-beat acceptance and input acceptance: the new block's data appears the next cycle. The old last beat is consumed exactly once.

## Test plan
Default parameters; block_in[r][c] = r*8 + c + 1 unless stated.
- Reset: hold rst_n=0 for 5 cycles -> valid_out=0, block_out all 0, idx_out=0, last_out=0, in_ready=1. No capture although valid_in=1.
- H2V2, ch_in=1, out_ready=1 -> 4 consecutive beats, idx 0..3, last_out only on k=3, ch_out=1.
  - k=0: out[0][0]=out[1][1]=1, out[7][7]=28.
  - k=3: out[0][0]=37, out[7][7]=64.
- H2V1 with out_ready=0 for 3 cycles at k=1 -> block_out and idx_out=1 stable throughout. out[5][0]=45, out[5][1]=45, out[5][7]=48. Then IDLE.
- Back-to-back: second block (ch_in=2, H1V1, all samples -5) presented during the final H2V2 beat -> in_ready=1 that cycle. Next cycle valid_out=1, ch_out=2, idx_out=0, last_out=1, all out=-5. No idle cycle between.
- H1V2 -> k=1 out[0][3]=36, out[1][3]=36, out[7][0]=57.
- Async reset mid-H2V2 after 2 beats, asserted between clock edges -> valid_out falls immediately. After release, a new H1V1 block emits with idx_out=0.
